add8_err_char: RTL

ADD8_ERR_CHAR -- requirements
Module: add8_err_char

---
 rtl/add8_err_pkg.sv | 36 +++
 rtl/add8_err_acc.sv | 82 ++++++++
 rtl/add8_err_char.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/add8_err_pkg.sv
// Shared types and constants for the 8-bit approximate-adder error characteriser.
// The optional squared-error output is enabled by the ADD8_ERR_MSE_EN macro.
package add8_err_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam int N_VEC     = 65536;
   localparam int DRAIN_CYC = 2;

   localparam int OP_W      = 8;
   localparam int SUM_W     = 9;
   localparam int ERR_SUM_W = 25;
   localparam int CNT_W     = 17;
   localparam int MSE_W     = 34;

   localparam int VEC_W     = 2 * OP_W;
   localparam int SQ_W      = 2 * SUM_W;

   // Unsigned magnitude of the difference between two 9-bit sums.
   function automatic logic [SUM_W-1:0] abs_diff(input logic [SUM_W-1:0] x,
                                                 input logic [SUM_W-1:0] y);
      logic [SUM_W-1:0] d;
      if (x >= y) begin
         d = x - y;
      end else begin
         d = y - x;
      end
      return d;
   endfunction

endpackage

// File: rtl/add8_err_acc.sv
// Stage 2 of the characteriser: |error| of one captured vector and the
// running accumulators. Clear, abort-flush and reset all zero the results and
// take priority over an update arriving in the same cycle.
// With ADD8_ERR_MSE_EN defined a squared-error accumulator is added.
module add8_err_acc
   import add8_err_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   input  logic                 flush,
   input  logic                 en,
   input  logic [SUM_W-1:0]     approx_sum,
   input  logic [SUM_W-1:0]     exact_sum,
   output logic [ERR_SUM_W-1:0] err_sum,
   output logic [SUM_W-1:0]     wce,
   output logic [CNT_W-1:0]     err_cnt
`ifdef ADD8_ERR_MSE_EN
   ,
   output logic [MSE_W-1:0]     mse_sum
`endif
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [SUM_W-1:0]     err_s;
   logic                 zap_s;
   logic [ERR_SUM_W-1:0] err_sum_r;
   logic [SUM_W-1:0]     wce_r;
   logic [CNT_W-1:0]     err_cnt_r;

   // Error magnitude of the vector held in stage 1, plus the combined zeroing request.
   always_comb begin
      err_s = abs_diff(approx_sum, exact_sum);
      zap_s = rst | clr | flush;
   end

   // Running sum of |error|, worst-case |error| and count of erroneous vectors.
   always_ff @(posedge clk) begin
      if (zap_s) begin
         err_sum_r <= {ERR_SUM_W{1'b0}};
         wce_r     <= {SUM_W{1'b0}};
         err_cnt_r <= {CNT_W{1'b0}};
      end else if (en) begin
         err_sum_r <= err_sum_r + ERR_SUM_W'(err_s);
         if (err_s > wce_r) begin
            wce_r <= err_s;
         end
         if (err_s != {SUM_W{1'b0}}) begin
            err_cnt_r <= err_cnt_r + CNT_ONE;
         end
      end
   end

   assign err_sum = err_sum_r;
   assign wce     = wce_r;
   assign err_cnt = err_cnt_r;

`ifdef ADD8_ERR_MSE_EN
   logic [SQ_W-1:0]  sq_s;
   logic [MSE_W-1:0] mse_sum_r;

   // Square of the error magnitude (at most 511^2, fits 18 bits).
   always_comb begin
      sq_s = SQ_W'(err_s) * SQ_W'(err_s);
   end

   // Sum of squared errors, same clear/flush/update timing as err_sum.
   always_ff @(posedge clk) begin
      if (zap_s) begin
         mse_sum_r <= {MSE_W{1'b0}};
      end else if (en) begin
         mse_sum_r <= mse_sum_r + MSE_W'(sq_s);
      end
   end

   assign mse_sum = mse_sum_r;
`else
   // Squared-error path is not built in this configuration.
`endif

endmodule

// File: rtl/add8_err_char.sv
// Exhaustive error characteriser for an external combinational 8-bit
// approximate adder. One sweep presents all 65536 operand pairs, compares the
// returned sum with the exact sum and accumulates error statistics.
// Optional feature: define ADD8_ERR_MSE_EN to add the mse_sum output.
module add8_err_char
   import add8_err_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   output logic                 busy,
   output logic                 done,
   output logic [OP_W-1:0]      dut_a,
   output logic [OP_W-1:0]      dut_b,
   input  logic [SUM_W-1:0]     dut_o,
   output logic [ERR_SUM_W-1:0] err_sum,
   output logic [SUM_W-1:0]     wce,
   output logic [CNT_W-1:0]     err_cnt
`ifdef ADD8_ERR_MSE_EN
   ,
   output logic [MSE_W-1:0]     mse_sum
`endif
);

   localparam logic [VEC_W-1:0] VEC_LAST   = VEC_W'(N_VEC - 1);
   localparam logic [VEC_W-1:0] VEC_ONE    = {{(VEC_W-1){1'b0}}, 1'b1};
   localparam logic [1:0]       DRAIN_LAST = 2'(DRAIN_CYC - 1);

   state_e            state_r;
   logic [VEC_W-1:0]  vec_cnt_r;
   logic [1:0]        drain_cnt_r;
   logic              busy_r;
   logic              done_r;
   logic [OP_W-1:0]   dut_a_r;
   logic [OP_W-1:0]   dut_b_r;

   logic              s1_valid_r;
   logic [SUM_W-1:0]  s1_o_r;
   logic [SUM_W-1:0]  s1_sum_r;

   logic [VEC_W-1:0]  vec_nxt_s;
   logic [SUM_W-1:0]  exact_s;
   logic              accept_s;
   logic              kill_s;
   logic              in_sweep_s;

   // Next vector index, exact reference sum and the start/abort qualifiers.
   always_comb begin
      vec_nxt_s  = vec_cnt_r + VEC_ONE;
      exact_s    = {1'b0, dut_a_r} + {1'b0, dut_b_r};
      accept_s   = (state_r == IDLE) && start && !abort;
      in_sweep_s = (state_r == SWEEP);
      if ((state_r == SWEEP) || (state_r == DRAIN)) begin
         kill_s = abort;
      end else begin
         kill_s = 1'b0;
      end
   end

   // Sweep controller: state, vector counter and registered operand/status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         vec_cnt_r   <= {VEC_W{1'b0}};
         drain_cnt_r <= 2'd0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         dut_a_r     <= {OP_W{1'b0}};
         dut_b_r     <= {OP_W{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               done_r  <= 1'b0;
               dut_a_r <= {OP_W{1'b0}};
               dut_b_r <= {OP_W{1'b0}};
               if (accept_s) begin
                  state_r   <= SWEEP;
                  vec_cnt_r <= {VEC_W{1'b0}};
                  busy_r    <= 1'b1;
               end else begin
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
               end
            end
            SWEEP: begin
               if (abort) begin
                  state_r   <= IDLE;
                  busy_r    <= 1'b0;
                  vec_cnt_r <= {VEC_W{1'b0}};
                  dut_a_r   <= {OP_W{1'b0}};
                  dut_b_r   <= {OP_W{1'b0}};
               end else if (vec_cnt_r == VEC_LAST) begin
                  state_r     <= DRAIN;
                  drain_cnt_r <= 2'd0;
                  vec_cnt_r   <= {VEC_W{1'b0}};
                  dut_a_r     <= {OP_W{1'b0}};
                  dut_b_r     <= {OP_W{1'b0}};
               end else begin
                  vec_cnt_r <= vec_nxt_s;
                  dut_a_r   <= vec_nxt_s[OP_W-1:0];
                  dut_b_r   <= vec_nxt_s[VEC_W-1:OP_W];
               end
            end
            DRAIN: begin
               if (abort) begin
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
               end else if (drain_cnt_r == DRAIN_LAST) begin
                  state_r <= DONE;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
               end else begin
                  drain_cnt_r <= drain_cnt_r + 2'd1;
               end
            end
            DONE: begin
               state_r <= IDLE;
               done_r  <= 1'b0;
            end
            default: begin
               state_r     <= IDLE;
               vec_cnt_r   <= {VEC_W{1'b0}};
               drain_cnt_r <= 2'd0;
               busy_r      <= 1'b0;
               done_r      <= 1'b0;
               dut_a_r     <= {OP_W{1'b0}};
               dut_b_r     <= {OP_W{1'b0}};
            end
         endcase
      end
   end

   // Stage 1: capture the returned sum and exact sum of the vector presented this cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_r <= 1'b0;
         s1_o_r     <= {SUM_W{1'b0}};
         s1_sum_r   <= {SUM_W{1'b0}};
      end else if (in_sweep_s && !abort) begin
         s1_valid_r <= 1'b1;
         s1_o_r     <= dut_o;
         s1_sum_r   <= exact_s;
      end else begin
         s1_valid_r <= 1'b0;
      end
   end

   add8_err_acc u_acc (
      .clk        (clk),
      .rst        (rst),
      .clr        (accept_s),
      .flush      (kill_s),
      .en         (s1_valid_r),
      .approx_sum (s1_o_r),
      .exact_sum  (s1_sum_r),
      .err_sum    (err_sum),
      .wce        (wce),
      .err_cnt    (err_cnt)
`ifdef ADD8_ERR_MSE_EN
      ,
      .mse_sum    (mse_sum)
`endif
   );

   assign busy  = busy_r;
   assign done  = done_r;
   assign dut_a = dut_a_r;
   assign dut_b = dut_b_r;

endmodule
